// File: rtl/decode_if.sv
// Fetch/Writeback inputs and decoded ID-side outputs of the decode stage.
// decode_stage uses the slave view; the driver of the stage uses master.
interface decode_if;
    logic [31:0] InstrF;
    logic [31:0] PCF_postff;
    logic [31:0] PCPlus4F;
    logic        StallD;
    logic        FlushD;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ImmExtD;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  RdD;
    logic        RegWriteD;
    logic        MemWriteD;
    logic        JumpD;
    logic        BranchD;
    logic        ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;

    modport slave (
        input  InstrF, PCF_postff, PCPlus4F, StallD, FlushD, RegWriteW, RdW, ResultW,
        output PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
               RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD
    );

    modport master (
        output InstrF, PCF_postff, PCPlus4F, StallD, FlushD, RegWriteW, RdW, ResultW,
        input  PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD,
               RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register with stall/flush, 32x32 register file
// with write-through reads, and control/immediate decode of the held instruction.
module decode_stage (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        imm_src_e   imm_src;
    } ctrl_t;

    logic [31:0]       instr_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc_plus4_d;
    logic [31:0][31:0] rf;
    ctrl_t             ctrl;
    logic [31:0]       imm_ext;

    // Flush outranks stall so a squashed slot never survives a held pipeline.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushD) begin
            instr_d    <= '0;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (!bus.StallD) begin
            instr_d    <= bus.InstrF;
            pc_d       <= bus.PCF_postff;
            pc_plus4_d <= bus.PCPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rf <= '0;
        else if (bus.RegWriteW && bus.RdW != 5'd0)
            rf[bus.RdW] <= bus.ResultW;
    end

    wire [6:0] opcode = instr_d[6:0];
    wire [2:0] funct3 = instr_d[14:12];
    wire [4:0] rs1    = instr_d[19:15];
    wire [4:0] rs2    = instr_d[24:20];

    // Write-through bypass so the Writeback result is usable in the same cycle.
    assign bus.RD1D = (rs1 == 5'd0) ? 32'd0 :
                      (bus.RegWriteW && bus.RdW == rs1) ? bus.ResultW : rf[rs1];
    assign bus.RD2D = (rs2 == 5'd0) ? 32'd0 :
                      (bus.RegWriteW && bus.RdW == rs2) ? bus.ResultW : rf[rs2];

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    always_comb begin
        ctrl = '{default: '0, imm_src: IMM_NONE};
        case (opcode)
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_I;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = 2'b01;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.imm_src   = IMM_S;
                ctrl.alu_src   = 1'b1;
            end
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_dec(funct3, instr_d[30], 1'b1);
            end
            OP_I: begin
                ctrl.reg_write = 1'b1;
                ctrl.imm_src   = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_dec(funct3, instr_d[30], 1'b0);
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.imm_src  = IMM_B;
                ctrl.alu_ctrl = 3'b001;
            end
            OP_JAL: begin
                ctrl.jump       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.imm_src    = IMM_J;
                ctrl.result_src = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_ext = 32'd0;
        case (ctrl.imm_src)
            IMM_I:   imm_ext = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   imm_ext = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   imm_ext = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_J:   imm_ext = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                instr_d[20], instr_d[30:21], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    assign bus.PCD         = pc_d;
    assign bus.PCPlus4D    = pc_plus4_d;
    assign bus.ImmExtD     = imm_ext;
    assign bus.Rs1D        = rs1;
    assign bus.Rs2D        = rs2;
    assign bus.RdD         = instr_d[11:7];
    assign bus.RegWriteD   = ctrl.reg_write;
    assign bus.MemWriteD   = ctrl.mem_write;
    assign bus.JumpD       = ctrl.jump;
    assign bus.BranchD     = ctrl.branch;
    assign bus.ALUSrcD     = ctrl.alu_src;
    assign bus.ResultSrcD  = ctrl.result_src;
    assign bus.ALUControlD = ctrl.alu_ctrl;
endmodule

// File: doc/decode_stage.md
# decode_stage

Second stage of the five-stage RV32I pipeline. Holds the IF/ID pipeline register with stall and flush control, and the 32×32 register file written back from Writeback. Decodes the registered instruction into control signals, register operands and a sign-extended immediate for the ID/EX register. Consumes the Fetch outputs (instruction, PC, PC+4) and the Writeback result bus.

## Interface
- No parameters.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- InstrF  input  32  instruction fetched this cycle.
- PCF_postff  input  32  PC of InstrF.
- PCPlus4F  input  32  PC+4 of InstrF.
- StallD  input  1  hold the IF/ID register.
- FlushD  input  1  load a bubble into the IF/ID register.
- RegWriteW  input  1  Writeback register-write enable.
- RdW  input  5  Writeback destination register.
- ResultW  input  32  Writeback data.
- PCD, PCPlus4D  output  32  registered PC and PC+4.
- RD1D, RD2D  output  32  rs1 and rs2 read data, with write-through applied.
- ImmExtD  output  32  sign-extended immediate.
- Rs1D, Rs2D, RdD  output  5  fields InstrD[19:15], InstrD[24:20], InstrD[11:7].
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  output  1  control signals.
- ResultSrcD  output  2  result source: 00 ALU, 01 memory, 10 PC+4.
- ALUControlD  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.

## Operation
- **IF/ID register (InstrD, PCD, PCPlus4D).** Priority on each rising edge:
  - rst, then FlushD: all three fields load 0.
  - StallD: hold.
  - Otherwise: load InstrF, PCF_postff and PCPlus4F.
  - If FlushD and StallD are both high, the flush wins.
- **Register file.** 32 entries. Reset clears all entries to 0.
- **Register write.** On the clock edge, when RegWriteW=1 and RdW≠0, write ResultW to entry RdW. Writes to x0 are ignored. Writes are not gated by StallD or FlushD.
- **Register read.** Reads are combinational.
  - RD1D = 0 when Rs1D=0.
  - Otherwise RD1D = ResultW when RegWriteW=1 and RdW=Rs1D (write-through).
  - Otherwise RD1D = the stored entry.
  - RD2D follows the same rules using Rs2D.
- **Decode by opcode (InstrD[6:0]):**
  - 0000011 lw: RegWrite 1, ImmSrc I, ALUSrc 1, ResultSrc 01, ALU add.
  - 0100011 sw: MemWrite 1, ImmSrc S, ALUSrc 1, ALU add.
  - 0110011 R-type: RegWrite 1, ALUSrc 0, ResultSrc 00.
  - 0010011 I-type ALU: RegWrite 1, ImmSrc I, ALUSrc 1, ResultSrc 00.
  - 1100011 beq: Branch 1, ImmSrc B, ALUSrc 0, ALU sub.
  - 1101111 jal: Jump 1, RegWrite 1, ImmSrc J, ResultSrc 10.
  - Any other opcode, including 0x00000000: every control output 0, ALUControl 000, ImmExtD 0.
- **ALU selection for R-type and I-type ALU** (funct3 = InstrD[14:12]):
  - 000: add. R-type with funct7[5]=1 gives sub; I-type addi is always add.
  - 010: slt.
  - 110: or.
  - 111: and.
  - Any other funct3: add.
- **Immediate extension:**
  - I: {20{I[31]}, I[31:20]}.
  - S: {20{I[31]}, I[31:25], I[11:7]}.
  - B: {19{I[31]}, I[31], I[7], I[30:25], I[11:8], 0}.
  - J: {11{I[31]}, I[31], I[19:12], I[20], I[30:21], 0}.

## Timing
- Latency is one cycle from InstrF to the decoded outputs. All D-side outputs are combinational from InstrD and the register file.
- **Reset.** Takes effect on the first edge with rst=1.
  - Afterwards InstrD, PCD, PCPlus4D and all register entries are 0.
  - Hence every output is 0, including RD1D, RD2D, ImmExtD and all control signals.
- **Reset mid-operation.** An in-flight instruction is discarded and all register contents are lost. A RegWriteW write on the same edge as rst is dropped.
- **Write-through.** A value written at edge N is visible on RD1D/RD2D during the cycle before edge N. No separate negedge write is used.
- **Stall.** While StallD=1, the outputs stay stable except RD1D/RD2D, which still reflect register writes.
- **Flush.** After a flushed edge the outputs decode as a bubble: all control 0.

## Test plan
- **Reset.** Hold rst=1 for 1 cycle with InstrF=0x006283B3 → PCD=0, RdD=0, RegWriteD=0, RD1D=0, RD2D=0.
- **R-type with write-through.**
  - Stimulus: write x5=0x12345678 and x6=0x00000010 via RegWriteW. Then InstrF=0x006283B3 (add x7,x5,x6).
  - Required: Rs1D=5, Rs2D=6, RdD=7, RD1D=0x12345678, RD2D=0x10, RegWriteD=1, ALUSrcD=0, ALUControlD=000.
  - Then apply RegWriteW=1, RdW=5, ResultW=0xAAAA0000 in the same cycle → RD1D=0xAAAA0000.
- **Immediates.**
  - InstrF=0xFFF00093 (addi x1,x0,-1) → ImmExtD=0xFFFFFFFF, ALUSrcD=1, RD1D=0.
  - InstrF=0x0062A423 (sw x6,8(x5)) → ImmExtD=0x00000008, MemWriteD=1, RegWriteD=0.
  - InstrF=0x010000EF (jal x1,16) → ImmExtD=0x10, JumpD=1, ResultSrcD=10.
- **Stall and flush.**
  - Load PCF_postff=0x8, then apply StallD=1 for 2 cycles with PCF_postff=0xC → PCD stays 0x8.
  - Apply FlushD=1 and StallD=1 together → PCD=0 and all control 0.
- **x0 protection.** Apply RegWriteW=1, RdW=0, ResultW=0xDEADBEEF, then decode Rs1D=0 → RD1D=0.
